io_slave_regs: RTL



---
 rtl/io_slave_regs.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/io_slave_regs.sv
// IO_bus register slave: decodes its address window, runs the 4-phase handshake1_1/handshake1_2
// protocol, and serves NUM_RW control registers plus NUM_RO status words. Optional macro: IO_SLAVE_TIMEOUT_EN.
module io_slave_regs #(
  parameter logic [7:0] BASE_ADDR      = 8'h00,
  parameter int         NUM_RW         = 4,
  parameter int         NUM_RO         = 2,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            data_out,
  input  logic [7:0]             reg_address,
  input  logic                   RW,
  input  logic                   handshake1_1,
  output logic [31:0]            data_in,
  output logic                   handshake1_2,
  output logic [NUM_RW*32-1:0]   ctrl_regs,
  output logic [NUM_RW-1:0]      wr_strobe,
  input  logic [NUM_RO*32-1:0]   status_in,
  output logic                   timeout_flag
);

  localparam logic [8:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [8:0] ADDR_HI = 9'(int'(BASE_ADDR) + NUM_RW + NUM_RO - 1);

  if (int'(BASE_ADDR) + NUM_RW + NUM_RO > 256) begin : g_bad_window
    $error("io_slave_regs: address window does not fit below 256");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("io_slave_regs: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t      state, state_next;
  logic        strobe_prev;
  logic        hit, req, tmo;
  logic [7:0]  lat_addr;
  logic        lat_rw;
  logic [31:0] lat_data;
  logic [7:0]  idx;
  logic [31:0] regs [NUM_RW];
  logic [31:0] rd_mux, rd_data;

  assign hit = ({1'b0, reg_address} >= ADDR_LO) && ({1'b0, reg_address} <= ADDR_HI);
  assign req = (state == IDLE) && !strobe_prev && handshake1_1 && hit;
  assign idx = lat_addr - BASE_ADDR;

  // Control: state register and previous strobe (held at 1 so a strobe high across reset is not an edge)
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      strobe_prev <= 1'b1;
    end else begin
      state       <= state_next;
      strobe_prev <= handshake1_1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = ACCESS;
      ACCESS:  state_next = ACK;
      ACK:     if (!handshake1_1 || tmo) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch: bus inputs are frozen here and not looked at again
  always_ff @(posedge clk) begin
    if (req) begin
      lat_addr <= reg_address;
      lat_rw   <= RW;
      lat_data <= data_out;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (idx == 8'(i)) rd_mux = regs[i];
    for (int j = 0; j < NUM_RO; j++)
      if (idx == 8'(NUM_RW + j)) rd_mux = status_in[32*j +: 32];
  end

  // Access stage: register write, strobe pulse and read capture
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RW; i++) regs[i] <= '0;
      wr_strobe <= '0;
    end else begin
      wr_strobe <= '0;
      if (state == ACCESS && !lat_rw) begin
        for (int i = 0; i < NUM_RW; i++) begin
          if (idx == 8'(i)) begin
            regs[i]      <= lat_data;
            wr_strobe[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ACCESS) rd_data <= rd_mux;
  end

  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_ctrl
    assign ctrl_regs[32*gi +: 32] = regs[gi];
  end

  // Outputs are zero outside ACK so several slaves can be OR-combined
  assign handshake1_2 = (state == ACK);
  assign data_in      = (state == ACK && lat_rw) ? rd_data : '0;

`ifdef IO_SLAVE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] ack_cnt;
  logic             flag;

  assign tmo = (state == ACK) && handshake1_1 && (ack_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (state != ACK) ack_cnt <= '0;
    else if (handshake1_1) ack_cnt <= ack_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) flag <= 1'b0;
    else if (tmo) flag <= 1'b1;
  end

  assign timeout_flag = flag;
`else
  assign tmo          = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule
